// File: rtl/vc_mem_msg_pkg.sv
// Memory message layout, type codes and generator state encoding shared by vc_mem_test_gen.
// Latency: none, definitions only.
// Backpressure: not applicable.
`ifndef VC_MEM_MSG_PKG_SV
`define VC_MEM_MSG_PKG_SV

`define VC_MEM_REQ_MSG_SZ(a,d)          (3+(a)+2+(d))
`define VC_MEM_REQ_MSG_TYPE_FIELD(a,d)  (3+(a)+2+(d)-1):((a)+2+(d))
`define VC_MEM_REQ_MSG_ADDR_FIELD(a,d)  ((a)+2+(d)-1):(2+(d))
`define VC_MEM_REQ_MSG_LEN_FIELD(a,d)   (2+(d)-1):(d)
`define VC_MEM_REQ_MSG_DATA_FIELD(a,d)  ((d)-1):0

`define VC_MEM_RESP_MSG_SZ(d)           (3+2+(d))
`define VC_MEM_RESP_MSG_TYPE_FIELD(d)   (3+2+(d)-1):(2+(d))
`define VC_MEM_RESP_MSG_LEN_FIELD(d)    (2+(d)-1):(d)
`define VC_MEM_RESP_MSG_DATA_FIELD(d)   ((d)-1):0

package vc_mem_msg_pkg;

    localparam logic [2:0] MEM_TYPE_READ   = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE  = 3'd1;
    localparam logic [2:0] MEM_TYPE_AMOADD = 3'd2;
    localparam logic [2:0] MEM_TYPE_AMOAND = 3'd3;
    localparam logic [2:0] MEM_TYPE_AMOOR  = 3'd4;

    localparam logic [1:0] MEM_LEN_WORD = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_AMO  = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4
    } tg_state_t;

    function automatic logic [31:0] pat_word(input logic [31:0] seed, input logic [31:0] idx);
        return seed + idx;
    endfunction

endpackage

`endif

// File: rtl/vc_mem_test_gen_chk.sv
// Response checker: tracks expected response index, compares type/len/data, saturating error count.
// Latency: err_count updates the cycle after the offending response fires.
// Backpressure: none, observes fired responses only.
module vc_mem_test_gen_chk
    import vc_mem_msg_pkg::*;
#(
    parameter int          p_data_sz = 32,
    parameter logic [31:0] p_seed    = 32'h0a0b0c00,
    parameter int          p_idx_sz  = 7
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    clear_all,
    input  logic                                    clear_idx,
    input  logic                                    resp_fire,
    input  logic                                    inflight_zero,
    input  logic [2:0]                              exp_type,
    input  logic                                    check_data,
    input  logic [31:0]                             data_ofs,
    input  logic [`VC_MEM_RESP_MSG_SZ(p_data_sz)-1:0] resp_msg,
    output logic [15:0]                             err_count
);

    logic [p_idx_sz-1:0]  resp_idx;
    logic [2:0]           resp_type;
    logic [1:0]           resp_len;
    logic [p_data_sz-1:0] resp_data;
    logic [p_data_sz-1:0] exp_data;
    logic [1:0]           n_err;
    logic [16:0]          err_sum;

    assign resp_type = resp_msg[`VC_MEM_RESP_MSG_TYPE_FIELD(p_data_sz)];
    assign resp_len  = resp_msg[`VC_MEM_RESP_MSG_LEN_FIELD(p_data_sz)];
    assign resp_data = resp_msg[`VC_MEM_RESP_MSG_DATA_FIELD(p_data_sz)];
    assign exp_data  = p_data_sz'(pat_word(p_seed, 32'(resp_idx)) + data_ofs);

    // An unsolicited response counts once and is not matched against the sweep.
    always_comb begin
        n_err = 2'd0;
        if (resp_fire) begin
            if (inflight_zero) begin
                n_err = 2'd1;
            end else begin
                n_err = 2'(resp_type != exp_type)
                      + 2'(resp_len != MEM_LEN_WORD)
                      + 2'(check_data && (resp_data != exp_data));
            end
        end
    end

    assign err_sum = {1'b0, err_count} + {15'd0, n_err};

    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            err_count <= '0;
        end else if (err_sum[16]) begin
            err_count <= 16'hffff;
        end else begin
            err_count <= err_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_all || clear_idx) begin
            resp_idx <= '0;
        end else if (resp_fire && !inflight_zero) begin
            resp_idx <= resp_idx + p_idx_sz'(1);
        end
    end

endmodule

// File: rtl/vc_mem_test_gen.sv
// Write-all / read-back sweep generator for the test memory; AMO phase enabled by VC_MEM_TEST_GEN_AMO_EN.
// Latency: first request the cycle after go is sampled; done the cycle after the last read response.
// Backpressure: request held while memreq_rdy low; at most p_max_inflight requests outstanding.
module vc_mem_test_gen
    import vc_mem_msg_pkg::*;
#(
    parameter int          p_addr_sz      = 16,
    parameter int          p_data_sz      = 32,
    parameter logic [31:0] p_base_addr    = 32'h0,
    parameter int          p_num_words    = 64,
    parameter logic [31:0] p_seed         = 32'h0a0b0c00,
    parameter int          p_max_inflight = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                go,
    output logic                                                memreq_val,
    input  logic                                                memreq_rdy,
    output logic [`VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)-1:0]  memreq_msg,
    input  logic                                                memresp_val,
    output logic                                                memresp_rdy,
    input  logic [`VC_MEM_RESP_MSG_SZ(p_data_sz)-1:0]           memresp_msg,
    output logic                                                done,
    output logic                                                pass,
    output logic [15:0]                                         err_count
);

    localparam int                IDX_SZ   = $clog2(p_num_words + 1);
    localparam logic [IDX_SZ-1:0] LAST_IDX = IDX_SZ'(p_num_words);
    localparam logic [3:0]        MAX_INF  = 4'(p_max_inflight);
`ifdef VC_MEM_TEST_GEN_AMO_EN
    localparam logic [31:0]       RD_OFS   = 32'd1;
`else
    localparam logic [31:0]       RD_OFS   = 32'd0;
`endif

    tg_state_t            state, state_nxt;
    logic [IDX_SZ-1:0]    req_idx;
    logic [3:0]           inflight, inflight_nxt;
    logic                 in_phase, go_ok, phase_end;
    logic                 req_fire, resp_fire, resp_cnt, resp_dec;
    logic [2:0]           phase_type;
    logic                 check_data;
    logic [31:0]          data_ofs;
    logic [p_addr_sz-1:0] req_addr;
    logic [p_data_sz-1:0] req_data;

    assign in_phase    = (state == ST_WR) || (state == ST_AMO) || (state == ST_RD);
    assign go_ok       = go && ((state == ST_IDLE) || (state == ST_DONE));
    assign memreq_val  = in_phase && (req_idx < LAST_IDX) && (inflight < MAX_INF);
    // Ready is forced low while reset is held; IDLE then sinks stale responses.
    assign memresp_rdy = !reset && (state != ST_DONE);
    assign req_fire    = memreq_val && memreq_rdy;
    assign resp_fire   = memresp_val && memresp_rdy;
    assign resp_cnt    = resp_fire && in_phase;
    assign resp_dec    = resp_cnt && (inflight != 4'd0);

    always_comb begin
        inflight_nxt = inflight;
        if (req_fire && !resp_dec) begin
            inflight_nxt = inflight + 4'd1;
        end else if (!req_fire && resp_dec) begin
            inflight_nxt = inflight - 4'd1;
        end
    end

    // A phase ends when every request has issued and its response has fired.
    assign phase_end = in_phase && (req_idx == LAST_IDX) && (inflight_nxt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (go) state_nxt = ST_WR;
`ifdef VC_MEM_TEST_GEN_AMO_EN
            ST_WR:            if (phase_end) state_nxt = ST_AMO;
            ST_AMO:           if (phase_end) state_nxt = ST_RD;
`else
            ST_WR:            if (phase_end) state_nxt = ST_RD;
`endif
            ST_RD:            if (phase_end) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_type = MEM_TYPE_READ;
        req_data   = '0;
        check_data = 1'b0;
        data_ofs   = '0;
        case (state)
            ST_WR: begin
                phase_type = MEM_TYPE_WRITE;
                req_data   = p_data_sz'(pat_word(p_seed, 32'(req_idx)));
            end
            ST_AMO: begin
                phase_type = MEM_TYPE_AMOADD;
                req_data   = p_data_sz'(1);
                check_data = 1'b1;
            end
            ST_RD: begin
                check_data = 1'b1;
                data_ofs   = RD_OFS;
            end
            default: ;
        endcase
    end

    assign req_addr   = p_addr_sz'(p_base_addr + (32'(req_idx) << 2));
    assign memreq_msg = {phase_type, req_addr, MEM_LEN_WORD, req_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            req_idx  <= '0;
            inflight <= '0;
        end else if (go_ok || phase_end) begin
            req_idx  <= '0;
            inflight <= '0;
        end else begin
            if (req_fire) req_idx <= req_idx + IDX_SZ'(1);
            inflight <= inflight_nxt;
        end
    end

    vc_mem_test_gen_chk #(
        .p_data_sz (p_data_sz),
        .p_seed    (p_seed),
        .p_idx_sz  (IDX_SZ)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .clear_all     (go_ok),
        .clear_idx     (phase_end),
        .resp_fire     (resp_cnt),
        .inflight_zero (inflight == 4'd0),
        .exp_type      (phase_type),
        .check_data    (check_data),
        .data_ofs      (data_ofs),
        .resp_msg      (memresp_msg),
        .err_count     (err_count)
    );

    assign done = (state == ST_DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_vc_mem_test_gen.sv
// Bench for vc_mem_test_gen: behavioural memory with random stalls, request scoreboard, sweep table.
module tb_vc_mem_test_gen;

    localparam int          N    = 8;
    localparam int          MAXF = 3;
    localparam logic [31:0] SEED = 32'h0a0b0c00;

    typedef struct { logic [2:0] typ; logic [15:0] addr; logic [31:0] data; } req_t;
    typedef struct { logic [2:0] typ; logic [1:0] len; logic [31:0] data; int dly; } resp_t;
    typedef struct { int rq_dly; int rs_dly; int fault; bit unsol; int exp_err; bit exp_pass; } vec_t;

    logic        clk, reset, go;
    logic        memreq_val, memreq_rdy;
    logic [52:0] memreq_msg;
    logic        memresp_val, memresp_rdy;
    logic [36:0] memresp_msg;
    logic        done, pass;
    logic [15:0] err_count;

    vc_mem_test_gen #(
        .p_addr_sz      (16),
        .p_data_sz      (32),
        .p_base_addr    (32'h0),
        .p_num_words    (N),
        .p_seed         (SEED),
        .p_max_inflight (MAXF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_t        exp_q[$];
    resp_t       resp_q[$];
    logic [31:0] mem [int];
    int errors = 0, checks = 0;
    int outst, rd_cnt, rd_resp, step_no, last_rd_step, cur_rq_dly, cur_rs_dly, cur_fault;
    bit ovf, fault_done, inj_unsol;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, resolve what fires at the next rising edge.
    task automatic step(input bit go_in, input bit rst_in);
        bit    rq_fire, rs_fire;
        req_t  e;
        resp_t r;
        int    w;
        @(negedge clk);
        step_no++;
        go    = go_in;
        reset = rst_in;
        if (rst_in) begin
            memreq_rdy  = 1'b0;
            memresp_val = 1'b0;
        end else begin
            memreq_rdy = ($urandom_range(0, cur_rq_dly) == 0);
            if (inj_unsol) begin
                memreq_rdy  = 1'b0;
                memresp_val = 1'b1;
                memresp_msg = {3'd1, 2'd0, 32'h0};
            end else if (resp_q.size() > 0 && resp_q[0].dly == 0) begin
                memresp_val = 1'b1;
                memresp_msg = {resp_q[0].typ, resp_q[0].len, resp_q[0].data};
            end else begin
                memresp_val = 1'b0;
                if (resp_q.size() > 0) resp_q[0].dly--;
            end
        end
        #1;
        rq_fire = memreq_val && memreq_rdy;
        rs_fire = memresp_val && memresp_rdy;
        if (rs_fire && !inj_unsol) begin
            if (resp_q[0].typ == 3'd0) begin
                rd_resp++;
                if (rd_resp == N) last_rd_step = step_no;
            end
            void'(resp_q.pop_front());
            outst--;
        end
        if (rq_fire) begin
            outst++;
            if (outst > MAXF) ovf = 1'b1;
            check("req_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_hdr", memreq_msg[52:32], {e.typ, e.addr, 2'b00});
                if (e.typ != 3'd0) check("req_data", memreq_msg[31:0], e.data);
            end
            w     = int'(memreq_msg[49:34] >> 2);
            r.typ = memreq_msg[52:50];
            r.len = 2'd0;
            r.dly = int'($urandom_range(0, cur_rs_dly));
            case (r.typ)
                3'd1: begin
                    mem[w] = memreq_msg[31:0];
                    r.data = $urandom;
                    if (cur_fault == 2 && !fault_done) begin
                        r.len      = 2'd1;
                        fault_done = 1'b1;
                    end
                end
                3'd2: begin
                    r.data = mem.exists(w) ? mem[w] : 32'h0;
                    mem[w] = r.data + memreq_msg[31:0];
                end
                default: begin
                    r.data = mem.exists(w) ? mem[w] : 32'h0;
                    rd_cnt++;
                    if (cur_fault == 1 && rd_cnt == 3) r.data = 32'hdeadbeef;
                end
            endcase
            resp_q.push_back(r);
        end
    endtask

    task automatic start_sweep(input vec_t v);
        cur_rq_dly = v.rq_dly;
        cur_rs_dly = v.rs_dly;
        cur_fault  = v.fault;
        rd_cnt = 0; rd_resp = 0; last_rd_step = -10; outst = 0;
        ovf = 1'b0; fault_done = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back('{3'd1, 16'(4 * i), SEED + 32'(i)});
`ifdef VC_MEM_TEST_GEN_AMO_EN
        for (int i = 0; i < N; i++) exp_q.push_back('{3'd2, 16'(4 * i), 32'd1});
`endif
        for (int i = 0; i < N; i++) exp_q.push_back('{3'd0, 16'(4 * i), 32'd0});
        step(1'b1, 1'b0);
        inj_unsol = v.unsol;
        step(1'b0, 1'b0);
        inj_unsol = 1'b0;
        check("first_req_val", memreq_val, 1);
        check("go_clears_err", err_count, 0);
    endtask

    task automatic finish_sweep(input vec_t v);
        int budget;
        budget = 0;
        while (done !== 1'b1 && budget < 3000) begin
            step(1'b0, 1'b0);
            budget++;
        end
        check("sweep_done", done, 1);
        check("done_latency", step_no - last_rd_step, 1);
        check("err_count", err_count, v.exp_err);
        check("pass", pass, v.exp_pass);
        check("all_reqs_issued", exp_q.size(), 0);
        check("all_resps_taken", resp_q.size(), 0);
        check("inflight_bound", ovf, 0);
    endtask

    initial begin
        int budget;
        vecs[0] = '{0, 0,  0, 1'b0, 0, 1'b1};  // zero-delay memory
        vecs[1] = '{3, 10, 0, 1'b0, 0, 1'b1};  // random source/sink stalls
        vecs[2] = '{0, 0,  1, 1'b0, 1, 1'b0};  // third read returns deadbeef
        vecs[3] = '{1, 2,  2, 1'b0, 1, 1'b0};  // first write response has len=1
        vecs[4] = '{0, 0,  0, 1'b1, 1, 1'b0};  // unsolicited write response in WR
        vecs[5] = '{2, 5,  0, 1'b0, 0, 1'b1};  // rerun from DONE clears err_count

        go = 0; reset = 1; memreq_rdy = 0; memresp_val = 0; memresp_msg = '0;
        step_no = 0; inj_unsol = 0; cur_rq_dly = 0; cur_rs_dly = 0; cur_fault = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("rst_req_val", memreq_val, 0);
        check("rst_resp_rdy", memresp_rdy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        step(1'b0, 1'b0);
        check("idle_resp_rdy", memresp_rdy, 1);
        check("idle_req_val", memreq_val, 0);

        for (int t = 0; t < 6; t++) begin
            start_sweep(vecs[t]);
            finish_sweep(vecs[t]);
        end

        // Reset in RD after two read responses, then drain stale responses in IDLE.
        start_sweep(vecs[0]);
        budget = 0;
        while (rd_resp < 2 && budget < 2000) begin
            step(1'b0, 1'b0);
            budget++;
        end
        check("reached_rd", rd_resp >= 2, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("midrst_req_val", memreq_val, 0);
        check("midrst_resp_rdy", memresp_rdy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_err", err_count, 0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        check("stale_drained", resp_q.size(), 0);
        check("stale_no_err", err_count, 0);
        check("stale_idle_val", memreq_val, 0);
        check("stale_not_done", done, 0);
        start_sweep(vecs[0]);
        finish_sweep(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vc_mem_test_gen.md
Name: vc_mem_test_gen

Overview:
- Self-checking memory traffic generator for the single-port test memory.
- Sits directly upstream of the memory: drives memreq val/rdy/msg and consumes memresp val/rdy/msg.
- Runs a write-all / read-back sweep over an address range and counts mismatches.
- Used in unit benches and as a built-in self-test in integration harnesses.

Parameters:
- p_addr_sz, 16, memreq address width in bits.
- p_data_sz, 32, memreq/memresp data width in bits; must be 32.
- p_base_addr, 0, byte address of word 0; must be 4-byte aligned.
- p_num_words, 64, words in the sweep, 1..2^(p_addr_sz-2).
- p_seed, 32'h0a0b0c00, base of the data pattern.
- p_max_inflight, 4, maximum outstanding requests, 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- go  in  1  pulse: start a sweep; sampled only in IDLE or DONE
- memreq_val  out  1  request valid
- memreq_rdy  in  1  request ready
- memreq_msg  out  3+p_addr_sz+2+p_data_sz  {type, addr, len, data}
- memresp_val  in  1  response valid
- memresp_rdy  out  1  response ready
- memresp_msg  in  3+2+p_data_sz  {type, len, data}
- done  out  1  sweep finished
- pass  out  1  done and err_count == 0
- err_count  out  16  mismatches, saturating at 16'hffff

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-high, named reset.
- Message format:
  - Type codes: read=0, write=1, amoadd=2, amoand=3, amoor=4.
  - len=0 means a full word. The block always issues len=0.
- Reset values: memreq_val=0, memresp_rdy=0, done=0, pass=0, err_count=0, state=IDLE, all counters=0.
- Pattern: pat(i) = p_seed + i (mod 2^32); addr(i) = p_base_addr + 4*i.
- States:
  - IDLE: go -> WR; clear err_count, req_idx, resp_idx, inflight.
  - WR: issue write(addr(i), pat(i)) for i = 0..N-1. Move to RD once all N write responses are accepted (or to AMO when the optional feature is enabled).
  - RD: issue read(addr(i)) for i = 0..N-1. Move to DONE once all N read responses are accepted.
  - DONE: done=1 and pass valid, held until go (-> WR, same clearing as IDLE) or reset.
- Request side:
  - memreq_val is a function of registered state only, never of memreq_rdy.
  - memreq_val=1 iff req_idx < N and inflight < p_max_inflight.
  - A request fires on val&rdy; req_idx then increments.
  - The first request is valid in the cycle after go is sampled.
- Response side:
  - memresp_rdy=1 in WR, RD and AMO.
  - memresp_rdy=0 in DONE.
  - memresp_rdy=1 in IDLE, where responses are discarded and not counted.
- inflight counter:
  - +1 on a request fire, -1 on a response fire. Both in the same cycle: unchanged.
  - Responses are in order; resp_idx gives the expected index.
- Checks, each +1 to err_count:
  - Response type does not match the phase type.
  - len != 0.
  - RD data != pat(resp_idx).
  - Response accepted with inflight == 0; counted, and inflight is not decremented.
- Write-response data is don't-care.
- Phase change requires inflight == 0; there is no request overlap across phases.
- done rises the cycle after the last RD response fires.
- N=1 is legal: one write, then one read.
- Reset mid-sweep returns to IDLE. Stale responses arriving afterwards are discarded in IDLE.

Optional Feature:
- Macro: VC_MEM_TEST_GEN_AMO_EN.
- Defined:
  - An AMO state sits between WR and RD.
  - AMO issues amoadd(addr(i), 1). Each response must be type amoadd with data pat(i).
  - RD then expects pat(i)+1.
- Undefined:
  - No AMO state; WR goes directly to RD.
  - RD expects pat(i).

Decomposition:
- Package vc_mem_msg_pkg holds:
  - Type code constants.
  - Field-width and field-range macros for req/resp messages, parameterized by addr/data size.
  - State enum localparams for this block.
- One sub-module, vc_mem_test_gen_chk: the response checker. It owns resp_idx, err_count saturation and the expected-data computation.

Test Plan:
- Basic sweep:
  - Stimulus: N=4, seed 0a0b0c00, zero-delay memory, go pulse.
  - Required: writes to 0x0,4,8,c with data 0a0b0c00..0a0b0c03; 4 reads return matching data; done=1, pass=1, err_count=0.
- Backpressure:
  - Stimulus: random-delay source/sink around the memory (max 3/10), N=16.
  - Required: never more than 4 requests outstanding; pass=1.
- Fault injection:
  - Stimulus: bench corrupts the 3rd read response data to deadbeef.
  - Required: err_count=1, pass=0, done=1.
- Protocol errors:
  - Stimulus: in WR, an unsolicited response with inflight=0; separately, a response with len=1.
  - Required: each increments err_count by 1.
- Reset and restart:
  - Stimulus: reset in RD after 2 reads, then go.
  - Required: outputs return to reset values; the full sweep reruns and passes. A second go while in DONE reruns and clears err_count.
- AMO variant:
  - Stimulus: with VC_MEM_TEST_GEN_AMO_EN, N=2.
  - Required: amoadd responses 0a0b0c00, 0a0b0c01; reads return 0a0b0c01, 0a0b0c02; pass=1.
